// File: rtl/uart_pkg.sv
// uart_pkg -- shared UART definitions, used by both the receiver and the transmitter.
//   uart_state_e : frame-level state encoding (IDLE, START, DATA, PARITY, STOP)
//   parity_e     : parity mode constants
//   maj3         : 2-of-3 vote, used by the oversampling build (UART_RX_MAJORITY_EN)
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_axis_if.sv
// uart_rx_axis_if -- AXI-Stream style word output of the UART receiver.
//   m_data       : received word, LSB first on the line
//   m_valid      : word held and valid
//   m_ready      : consumer accepts the held word
//   m_parity_err : parity mismatch on the held word (qualified by m_valid)
//   m_frame_err  : stop bit sampled low on the held word (qualified by m_valid)
interface uart_rx_axis_if #(
  parameter int WORD_LEN = 8
);
  logic [WORD_LEN-1:0] m_data;
  logic                m_valid;
  logic                m_ready;
  logic                m_parity_err;
  logic                m_frame_err;

  modport master (output m_data, m_valid, m_parity_err, m_frame_err, input m_ready);
  modport slave  (input m_data, m_valid, m_parity_err, m_frame_err, output m_ready);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync -- 2-flop synchronizer for the serial line plus falling-edge detect.
//   clk, rst : clock, asynchronous active-high reset
//   rx_i     : raw asynchronous line (idle high)
//   bit_o    : line value used for bit decisions; with UART_RX_MAJORITY_EN defined it is a
//              2-of-3 vote over the synchronized samples one cycle before, at, and one
//              cycle after the current cycle, otherwise the plain synchronized value
//   fall_o   : synchronized high-to-low transition, only once the line has been seen high
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic bit_o,
  output logic fall_o
);
  logic       s1_q, s2_q, prev_q, armed_q;
  logic [1:0] vld_q;

  // Flops reset to 1 (idle). vld_q marks when s2_q carries real line data, so a line that
  // is low while coming out of reset cannot look like a start edge: armed_q only sets once
  // the real line has been seen high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
      vld_q   <= 2'b00;
    end else begin
      s1_q   <= rx_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      vld_q  <= {vld_q[0], 1'b1};
      if (vld_q[1] && s2_q) armed_q <= 1'b1;
    end
  end

  assign fall_o = armed_q & prev_q & ~s2_q;

`ifdef UART_RX_MAJORITY_EN
  // s1_q is one cycle ahead of s2_q, giving the "target+1" sample without shifting the
  // decision point, so frame timing matches the single-sample build.
  assign bit_o = uart_pkg::maj3(prev_q, s2_q, s1_q);
`else
  assign bit_o = s2_q;
`endif

endmodule

// File: rtl/uart_rx_axis.sv
// uart_rx_axis -- UART receiver with a one-word AXI-Stream style output register.
//   Parameters: CLK_RATE (Hz), BAUD, WORD_LEN (5..9), PARITY ("none"/"even"/"odd")
//   clk, rst : clock, asynchronous active-high reset
//   uart_rx  : asynchronous serial input, idle high
//   m        : output stream (uart_rx_axis_if.master)
//   overrun  : one-cycle pulse when a completed word is dropped because the slot was full
//   Optional: define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions.
module uart_rx_axis
  import uart_pkg::*;
#(
  parameter int    CLK_RATE = 50_000_000,
  parameter int    BAUD     = 115200,
  parameter int    WORD_LEN = 8,
  parameter string PARITY   = "even"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  uart_rx_axis_if.master        m,
  output logic                  overrun
);
  localparam int BIT_DIV  = CLK_RATE / BAUD;
  localparam int HALF_DIV = BIT_DIV / 2;
  localparam int CW       = $clog2(BIT_DIV);
  localparam int BW       = $clog2(WORD_LEN + 1);
  localparam parity_e PMODE = (PARITY == "none") ? PAR_NONE :
                              (PARITY == "odd")  ? PAR_ODD  : PAR_EVEN;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_LEN - 1);
  localparam logic          PAR_INV  = (PMODE == PAR_ODD);

  logic rx_bit, rx_fall;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx_i   (uart_rx),
    .bit_o  (rx_bit),
    .fall_o (rx_fall)
  );

  uart_state_e         state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic [WORD_LEN-1:0] sh_q, sh_d;
  logic                perr_q, perr_d;
  logic                done, ferr;
  logic                at_bit;

  assign at_bit = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = at_bit ? '0 : cnt_q + 1'b1;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    perr_d  = perr_q;
    done    = 1'b0;
    ferr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A break (line held low after a frame error) never produces a new
        // falling edge, so START waits for the line to go high first.
        cnt_d  = '0;
        bcnt_d = '0;
        if (rx_fall) begin
          state_d = ST_START;
          perr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_bit ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (at_bit) begin
          sh_d   = {rx_bit, sh_q[WORD_LEN-1:1]};
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == BIT_LAST) state_d = (PMODE == PAR_NONE) ? ST_STOP : ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (at_bit) begin
          perr_d  = rx_bit ^ (^sh_q) ^ PAR_INV;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (at_bit) begin
          done    = 1'b1;
          ferr    = ~rx_bit;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One-word output slot. A word completing while the slot is popped this
  // cycle replaces it; a word completing into a stalled full slot is dropped.
  logic [WORD_LEN-1:0] data_q;
  logic                valid_q, operr_q, oferr_q, ovr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      operr_q <= 1'b0;
      oferr_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done) begin
        if (!valid_q || m.m_ready) begin
          data_q  <= sh_q;
          operr_q <= perr_q;
          oferr_q <= ferr;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (m.m_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign m.m_data       = data_q;
  assign m.m_valid      = valid_q;
  assign m.m_parity_err = operr_q;
  assign m.m_frame_err  = oferr_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
module tb_uart_rx_axis;
  localparam int BIT = 10;  // clocks per bit: 1 MHz / 100 kbaud

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic ready = 1'b0;
  logic ovr_e, ovr_o;

  int checks = 0;
  int errors = 0;
  int vld_cyc = 0;
  int ovr_cnt = 0;
  word_t got_e[$];
  word_t got_o[$];
  word_t exp_e[$];
  word_t exp_o[$];

  always #5 clk = ~clk;

  uart_rx_axis_if #(.WORD_LEN(8)) if_e ();
  uart_rx_axis_if #(.WORD_LEN(8)) if_o ();
  assign if_e.m_ready = ready;
  assign if_o.m_ready = 1'b1;

  uart_rx_axis #(.CLK_RATE(1_000_000), .BAUD(100_000), .WORD_LEN(8), .PARITY("even")) dut_e (
    .clk(clk), .rst(rst), .uart_rx(rx), .m(if_e), .overrun(ovr_e));

  uart_rx_axis #(.CLK_RATE(1_000_000), .BAUD(100_000), .WORD_LEN(8), .PARITY("odd")) dut_o (
    .clk(clk), .rst(rst), .uart_rx(rx), .m(if_o), .overrun(ovr_o));

  // Monitor on the falling edge, away from the edge where inputs and outputs change.
  always @(negedge clk) begin
    word_t w;
    if (!rst) begin
      if (if_e.m_valid) vld_cyc++;
      if (ovr_e) ovr_cnt++;
      if (if_e.m_valid && if_e.m_ready) begin
        w.d = if_e.m_data; w.pe = if_e.m_parity_err; w.fe = if_e.m_frame_err;
        got_e.push_back(w);
      end
      if (if_o.m_valid) begin
        w.d = if_o.m_data; w.pe = if_o.m_parity_err; w.fe = if_o.m_frame_err;
        got_o.push_back(w);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    tick(n);
  endtask

  // Start bit, 8 data bits LSB first, one parity bit, one stop bit; line left at stop value.
  task automatic send(input logic [7:0] d, input logic pbit, input logic stop);
    rx = 1'b0; tick(BIT);
    for (int i = 0; i < 8; i++) begin rx = d[i]; tick(BIT); end
    rx = pbit; tick(BIT);
    rx = stop; tick(BIT);
  endtask

  // Reference: error when the received parity bit differs from the rule for the mode.
  function automatic logic exp_perr(input logic [7:0] d, input logic pbit, input logic odd);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return pbit != (odd ? ((ones % 2) == 0) : ((ones % 2) == 1));
  endfunction

  task automatic clear();
    got_e.delete(); got_o.delete();
    vld_cyc = 0; ovr_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; ready = 1'b0;
    tick(3);
    checks++; if (if_e.m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_e.m_valid); end
    checks++; if (if_e.m_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", if_e.m_data); end
    checks++; if (if_e.m_parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", if_e.m_parity_err); end
    checks++; if (if_e.m_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", if_e.m_frame_err); end
    checks++; if (ovr_e !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", ovr_e); end
    rst = 1'b0;
    idle(20);
  endtask

  task automatic test_basic();
    clear(); ready = 1'b1;
    send(8'hA5, 1'b0, 1'b1); idle(20);
    checks++; if (got_e.size() !== 1) begin errors++; $display("FAIL basic_count: got %0d want 1", got_e.size()); end
    if (got_e.size() > 0) begin
      checks++; if (got_e[0].d !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", got_e[0].d); end
      checks++; if (got_e[0].pe !== 1'b0) begin errors++; $display("FAIL basic_perr: got %b want 0", got_e[0].pe); end
      checks++; if (got_e[0].fe !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b want 0", got_e[0].fe); end
    end
    checks++; if (vld_cyc !== 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d want 1", vld_cyc); end
  endtask

  task automatic test_parity();
    clear(); ready = 1'b1;
    send(8'h3C, 1'b1, 1'b1); idle(20);
    checks++; if (got_e.size() !== 1) begin errors++; $display("FAIL par_even_count: got %0d want 1", got_e.size()); end
    if (got_e.size() > 0) begin
      checks++; if (got_e[0].d !== 8'h3C) begin errors++; $display("FAIL par_even_data: got %h want 3c", got_e[0].d); end
      checks++; if (got_e[0].pe !== 1'b1) begin errors++; $display("FAIL par_even_perr: got %b want 1", got_e[0].pe); end
    end
    checks++; if (got_o.size() !== 1) begin errors++; $display("FAIL par_odd_count: got %0d want 1", got_o.size()); end
    if (got_o.size() > 0) begin
      checks++; if (got_o[0].d !== 8'h3C) begin errors++; $display("FAIL par_odd_data: got %h want 3c", got_o[0].d); end
      checks++; if (got_o[0].pe !== 1'b0) begin errors++; $display("FAIL par_odd_perr: got %b want 0", got_o[0].pe); end
    end
  endtask

  task automatic test_break();
    clear(); ready = 1'b1;
    send(8'h55, 1'b0, 1'b0);
    tick(50 * BIT);
    checks++; if (got_e.size() !== 1) begin errors++; $display("FAIL break_count_low: got %0d want 1", got_e.size()); end
    if (got_e.size() > 0) begin
      checks++; if (got_e[0].d !== 8'h55) begin errors++; $display("FAIL break_data: got %h want 55", got_e[0].d); end
      checks++; if (got_e[0].fe !== 1'b1) begin errors++; $display("FAIL break_ferr: got %b want 1", got_e[0].fe); end
    end
    idle(30);
    checks++; if (got_e.size() !== 1) begin errors++; $display("FAIL break_count_high: got %0d want 1", got_e.size()); end
  endtask

  task automatic test_back_to_back();
    clear(); ready = 1'b0;
    send(8'h11, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b1);
    idle(20);
    checks++; if (got_e.size() !== 0) begin errors++; $display("FAIL b2b_popped: got %0d want 0", got_e.size()); end
    checks++; if (if_e.m_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", if_e.m_valid); end
    checks++; if (if_e.m_data !== 8'h11) begin errors++; $display("FAIL b2b_held: got %h want 11", if_e.m_data); end
    checks++; if (ovr_cnt !== 1) begin errors++; $display("FAIL b2b_overrun: got %0d want 1", ovr_cnt); end
    ready = 1'b1;
    idle(20);
    checks++; if (got_e.size() !== 1) begin errors++; $display("FAIL b2b_pop_count: got %0d want 1", got_e.size()); end
    if (got_e.size() > 0) begin
      checks++; if (got_e[0].d !== 8'h11) begin errors++; $display("FAIL b2b_pop_data: got %h want 11", got_e[0].d); end
    end
    checks++; if (if_e.m_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", if_e.m_valid); end
  endtask

  task automatic test_glitch_reset();
    clear(); ready = 1'b1;
    rx = 1'b0; tick(3); idle(40);
    checks++; if (vld_cyc !== 0) begin errors++; $display("FAIL glitch_valid: got %0d want 0", vld_cyc); end
    // Abandon 0xFF mid-data, with the line held low across and after reset.
    rx = 1'b0; tick(BIT);
    rx = 1'b1; tick(3 * BIT + 5);
    rx = 1'b0; tick(2);
    rst = 1'b1; tick(3); rst = 1'b0;
    tick(20);
    idle(30);
    checks++; if (vld_cyc !== 0) begin errors++; $display("FAIL rst_abandon_valid: got %0d want 0", vld_cyc); end
    send(8'h81, 1'b0, 1'b1); idle(20);
    checks++; if (got_e.size() !== 1) begin errors++; $display("FAIL rst_next_count: got %0d want 1", got_e.size()); end
    if (got_e.size() > 0) begin
      checks++; if (got_e[0].d !== 8'h81) begin errors++; $display("FAIL rst_next_data: got %h want 81", got_e[0].d); end
      checks++; if (got_e[0].pe !== 1'b0 || got_e[0].fe !== 1'b0) begin
        errors++; $display("FAIL rst_next_flags: got pe=%b fe=%b want 0 0", got_e[0].pe, got_e[0].fe);
      end
    end
  endtask

  task automatic test_random();
    word_t w;
    clear(); ready = 1'b1;
    exp_e.delete(); exp_o.delete();
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      logic pbit, stop;
      d    = 8'($urandom_range(0, 255));
      pbit = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      w.d = d; w.fe = ~stop;
      w.pe = exp_perr(d, pbit, 1'b0); exp_e.push_back(w);
      w.pe = exp_perr(d, pbit, 1'b1); exp_o.push_back(w);
      send(d, pbit, stop);
      idle($urandom_range(2, 15));
    end
    idle(20);
    checks++; if (got_e.size() !== exp_e.size()) begin errors++; $display("FAIL rand_even_count: got %0d want %0d", got_e.size(), exp_e.size()); end
    checks++; if (got_o.size() !== exp_o.size()) begin errors++; $display("FAIL rand_odd_count: got %0d want %0d", got_o.size(), exp_o.size()); end
    for (int i = 0; i < exp_e.size() && i < got_e.size(); i++) begin
      checks++; if (got_e[i] !== exp_e[i]) begin
        errors++; $display("FAIL rand_even_word%0d: got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b",
                           i, got_e[i].d, got_e[i].pe, got_e[i].fe, exp_e[i].d, exp_e[i].pe, exp_e[i].fe);
      end
    end
    for (int i = 0; i < exp_o.size() && i < got_o.size(); i++) begin
      checks++; if (got_o[i] !== exp_o[i]) begin
        errors++; $display("FAIL rand_odd_word%0d: got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b",
                           i, got_o[i].d, got_o[i].pe, got_o[i].fe, exp_o[i].d, exp_o[i].pe, exp_o[i].fe);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_back_to_back();
    test_glitch_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_axis.md
UART_RX_AXIS -- requirements
Module: uart_rx_axis

Interface
REQ-001 SHALL have parameter CLK_RATE, default 50_000_000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line bit rate; BIT_DIV = CLK_RATE/BAUD (integer), HALF_DIV = BIT_DIV/2.
REQ-003 SHALL have parameter WORD_LEN, default 8, meaning data bits per frame (5..9).
REQ-004 SHALL have parameter PARITY, default "even", meaning parity mode: "none", "even" or "odd".
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port uart_rx  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port m_data  output  WORD_LEN  received word, LSB first on the line.
REQ-009 SHALL have port m_valid  output  1  AXI-Stream valid for m_data.
REQ-010 SHALL have port m_ready  input  1  AXI-Stream ready from consumer.
REQ-011 SHALL have port m_parity_err  output  1  parity mismatch on the held word, qualified by m_valid.
REQ-012 SHALL have port m_frame_err  output  1  stop bit sampled low on the held word, qualified by m_valid.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse: a completed word was dropped because m_valid was still high.

Function
REQ-014 SHALL pass uart_rx through a 2-flop synchronizer before any use; all timing below is relative to the synchronized signal.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP; reset state IDLE.
REQ-016 SHALL leave IDLE for START on a synchronized high-to-low transition, clearing the baud counter.
REQ-017 SHALL, in START, sample the line at baud count HALF_DIV-1; sample high -> IDLE (glitch rejected, no output); sample low -> DATA with counter cleared.
REQ-018 SHALL, in DATA, sample one bit at each baud count BIT_DIV-1 (mid-bit), shifting LSB first, and leave after WORD_LEN samples.
REQ-019 SHALL go DATA -> PARITY when PARITY is not "none", else DATA -> STOP.
REQ-020 SHALL, in PARITY, sample one bit at count BIT_DIV-1 and flag error if it differs from expected: even -> XOR of data, odd -> inverted XOR of data.
REQ-021 SHALL, in STOP, sample at count BIT_DIV-1, flag frame error if low, and return to IDLE on that same cycle (no wait for full stop bit).
REQ-022 SHALL load m_data, m_parity_err, m_frame_err and set m_valid on the clock edge following the stop sample (latency 1 cycle after stop mid-bit).
REQ-023 SHALL hold m_data and error flags stable while m_valid=1 and m_ready=0; clear m_valid on the cycle m_valid&&m_ready.
REQ-024 SHALL, when a word completes while m_valid=1 and m_ready=0, drop the new word, keep the held word, and pulse overrun for one cycle.
REQ-025 SHALL, when a word completes on the same cycle as m_valid&&m_ready, accept the new word (m_valid stays 1, no overrun).
REQ-026 SHALL report m_parity_err=0 always when PARITY is "none".
REQ-027 SHALL keep the baud counter width $clog2(BIT_DIV) and wrap it to 0 at BIT_DIV-1.
REQ-028 SHALL, on a frame error with line held low (break), not re-enter START until the line has been seen high.

Reset
REQ-029 SHALL on rst force state IDLE, counters 0, shift register 0, synchronizer flops 1, m_data 0, m_valid 0, m_parity_err 0, m_frame_err 0, overrun 0.
REQ-030 SHALL abandon a frame in progress on rst with no output produced, and resume detection after the line is seen high.

Configuration
REQ-031 SHALL, with UART_RX_MAJORITY_EN defined, decide each sampled bit (start, data, parity, stop) by 2-of-3 majority of samples at counts target-1, target, target+1.
REQ-032 SHALL, without UART_RX_MAJORITY_EN, use the single sample at the target count; frame timing and latency identical in both builds.

Structure
REQ-033 SHALL place the state encoding and parity-mode constants in the shared package uart_pkg, used also by the transmitter.
REQ-034 SHALL instantiate one sub-module uart_rx_sync (2-flop synchronizer plus falling-edge detect).

Verification (CLK_RATE=1_000_000, BAUD=100_000, BIT_DIV=10, WORD_LEN=8)
REQ-035 SHALL check: frame 0xA5, PARITY "even", parity bit 0, m_ready=1 -> m_data=0xA5, m_parity_err=0, m_frame_err=0, m_valid high one cycle.
REQ-036 SHALL check: frame 0x3C with parity bit forced 1 (even) -> m_data=0x3C, m_parity_err=1; PARITY "odd" with bit 1 -> m_parity_err=0.
REQ-037 SHALL check: 0x55 with stop bit low -> m_frame_err=1; line then held low 50 bit times -> no further words until line returns high.
REQ-038 SHALL check: two back-to-back frames 0x11, 0x22 with m_ready=0 -> m_data stays 0x11, overrun pulses once, then m_ready=1 pops 0x11 only.
REQ-039 SHALL check: 3-cycle low glitch on idle line -> no m_valid; rst asserted mid-DATA of 0xFF -> m_valid stays 0, next clean frame 0x81 received correctly.
